// File: rtl/universal_shift_reg_if.sv
// Bundles the control, data and status signals of universal_shift_reg.
// The master drives the operation request; the slave (the register) returns its state.
interface universal_shift_reg_if #(
  parameter int unsigned WIDTH = 8
) ();
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CntW-1:0]  cnt;
  logic             done;

  modport master (
    output en, mode, d, sin_r, sin_l,
    input  q, sout_r, sout_l, cnt, done
  );

  modport slave (
    input  en, mode, d, sin_r, sin_l,
    output q, sout_r, sout_l, cnt, done
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right/left (serial or rotate), parallel load,
// with a shift counter that wraps every WIDTH shifts and emits a one-cycle done pulse.
module universal_shift_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               ROTATE    = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  universal_shift_reg_if.slave bus
);
  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ModeHold = 2'b00,
    ModeShr  = 2'b01,
    ModeShl  = 2'b10,
    ModeLoad = 2'b11
  } mode_e;

  if (WIDTH < 2) begin : g_width_chk
    $error("universal_shift_reg: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shr_in, shl_in, shift;
  mode_e            mode;

  assign mode = mode_e'(bus.mode);

  // Rotation feeds the bit falling off the far end back in; serial pins are then unused.
  assign shr_in = ROTATE ? q_q[0]       : bus.sin_r;
  assign shl_in = ROTATE ? q_q[WIDTH-1] : bus.sin_l;
  assign shift  = bus.en && (mode == ModeShr || mode == ModeShl);

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (bus.en) begin
      unique case (mode)
        ModeHold: q_d = q_q;
        ModeShr:  q_d = {shr_in, q_q[WIDTH-1:1]};
        ModeShl:  q_d = {q_q[WIDTH-2:0], shl_in};
        ModeLoad: begin
          q_d   = bus.d;
          cnt_d = '0;
        end
      endcase
    end
    // Both directions share one counter so mixed sequences still wrap after WIDTH shifts.
    if (shift) begin
      if (cnt_q == CntLast) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.sout_r = q_q[0];
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.cnt    = cnt_q;
  assign bus.done   = done_q;

  cnt_in_range_a: assert property (@(posedge clk) disable iff (rst) cnt_q <= CntLast);
  done_single_a:  assert property (@(posedge clk) disable iff (rst) done_q |=> !done_q);
endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: a reference model pushes expected state into a
// scoreboard as each operation is driven; every scenario task pops and compares after the edge.
module tb_universal_shift_reg;
  localparam int unsigned      W  = 8;
  localparam logic [W-1:0]     RV = 8'h3C;

  typedef struct packed {
    logic [W-1:0] q;
    logic [3:0]   cnt;
    logic         done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t model;

  always #5 clk = ~clk;

  universal_shift_reg_if #(.WIDTH(W)) bus ();
  universal_shift_reg_if #(.WIDTH(W)) rbus ();

  universal_shift_reg #(.WIDTH(W), .RESET_VAL(RV), .ROTATE(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  universal_shift_reg #(.WIDTH(W), .RESET_VAL(8'h01), .ROTATE(1'b1)) dut_rot (
    .clk (clk),
    .rst (rst),
    .bus (rbus)
  );

  function automatic exp_t model_next(exp_t c, bit r, bit e, logic [1:0] m, logic [W-1:0] dd,
                                      bit sr, bit sl);
    exp_t n;
    n      = c;
    n.done = 1'b0;
    if (r) begin
      n.q   = RV;
      n.cnt = 4'd0;
    end else if (e) begin
      if (m == 2'b11) begin
        n.q   = dd;
        n.cnt = 4'd0;
      end else if (m != 2'b00) begin
        n.q = (m == 2'b01) ? {sr, c.q[W-1:1]} : {c.q[W-2:0], sl};
        if (c.cnt == 4'(W - 1)) begin
          n.cnt  = 4'd0;
          n.done = 1'b1;
        end else begin
          n.cnt = c.cnt + 4'd1;
        end
      end
    end
    return n;
  endfunction

  task automatic step(input bit r, input bit e, input logic [1:0] m, input logic [W-1:0] dd,
                      input bit sr, input bit sl);
    @(negedge clk);
    rst       = r;
    bus.en    = e;
    bus.mode  = m;
    bus.d     = dd;
    bus.sin_r = sr;
    bus.sin_l = sl;
    model     = model_next(model, r, e, m, dd, sr, sl);
    sb.push_back(model);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    step(1'b1, 1'b1, 2'b11, 8'hFF, 1'b1, 1'b1);
    e = sb.pop_front();
    checks++;
    if (bus.q !== e.q || bus.cnt !== e.cnt || bus.done !== e.done ||
        bus.sout_r !== e.q[0] || bus.sout_l !== e.q[W-1]) begin
      errors++;
      $display("FAIL reset_sb: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
               bus.q, bus.cnt, bus.done, e.q, e.cnt, e.done);
    end
    checks++;
    if (bus.q !== 8'h3C || bus.cnt !== 4'd0 || bus.done !== 1'b0 ||
        bus.sout_r !== 1'b0 || bus.sout_l !== 1'b0) begin
      errors++;
      $display("FAIL reset_value: got q=%h cnt=%0d done=%b sr=%b sl=%b, want 3c 0 0 0 0",
               bus.q, bus.cnt, bus.done, bus.sout_r, bus.sout_l);
    end
  endtask

  task automatic test_load_shift_right();
    exp_t         e;
    logic [W-1:0] seq;
    seq = 8'hA5;
    step(1'b0, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (bus.q !== e.q || bus.cnt !== e.cnt || bus.done !== e.done) begin
      errors++;
      $display("FAIL load: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
               bus.q, bus.cnt, bus.done, e.q, e.cnt, e.done);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.sout_r !== seq[i]) begin
        errors++;
        $display("FAIL shr_sout_r[%0d]: got %b, want %b", i, bus.sout_r, seq[i]);
      end
      step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b1);
      e = sb.pop_front();
      checks++;
      if (bus.q !== e.q || bus.cnt !== e.cnt || bus.done !== e.done ||
          bus.cnt !== 4'((i + 1) % 8) || bus.done !== 1'(i == 7)) begin
        errors++;
        $display("FAIL shr[%0d]: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                 i, bus.q, bus.cnt, bus.done, e.q, e.cnt, e.done);
      end
    end
    checks++;
    if (bus.q !== 8'h00) begin
      errors++;
      $display("FAIL shr_final: got q=%h, want 00", bus.q);
    end
  endtask

  task automatic test_shift_left();
    exp_t e;
    step(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0);
    void'(sb.pop_front());
    step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1);
    e = sb.pop_front();
    checks++;
    if (bus.q !== e.q || bus.cnt !== e.cnt || bus.done !== e.done ||
        bus.q !== 8'h03 || bus.cnt !== 4'd1 || bus.sout_l !== 1'b0 || bus.sout_r !== 1'b1) begin
      errors++;
      $display("FAIL shl: got q=%h cnt=%0d done=%b, want q=03 cnt=1 done=0",
               bus.q, bus.cnt, bus.done);
    end
  endtask

  task automatic test_rotate();
    @(negedge clk);
    rbus.en    = 1'b1;
    rbus.mode  = 2'b01;
    rbus.sin_r = 1'b0;
    rbus.sin_l = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rbus.q !== 8'h80 || rbus.cnt !== 4'd1) begin
      errors++;
      $display("FAIL rot_right: got q=%h cnt=%0d, want q=80 cnt=1", rbus.q, rbus.cnt);
    end
    @(negedge clk);
    rbus.mode = 2'b10;
    @(posedge clk);
    #1;
    checks++;
    if (rbus.q !== 8'h01 || rbus.cnt !== 4'd2) begin
      errors++;
      $display("FAIL rot_left: got q=%h cnt=%0d, want q=01 cnt=2", rbus.q, rbus.cnt);
    end
    @(negedge clk);
    rbus.en = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   pulses;
    step(1'b0, 1'b1, 2'b11, 8'h5A, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 8'h00, 1'b1, 1'b0);
      void'(sb.pop_front());
    end
    step(1'b0, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (bus.cnt !== 4'd5 || bus.q !== e.q || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mid_cnt5: got q=%h cnt=%0d, want q=%h cnt=5", bus.q, bus.cnt, e.q);
    end
    // rst rises between edges: nothing may move until the next rising edge.
    @(negedge clk);
    rst = 1'b1;
    #2;
    checks++;
    if (bus.q !== e.q || bus.cnt !== e.cnt || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_edge: got q=%h cnt=%0d, want q=%h cnt=%0d",
               bus.q, bus.cnt, e.q, e.cnt);
    end
    rst = 1'b0;
    step(1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 1'b1);
    e = sb.pop_front();
    checks++;
    if (bus.q !== RV || bus.cnt !== 4'd0 || bus.q !== e.q || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got q=%h cnt=%0d, want q=%h cnt=0", bus.q, bus.cnt, RV);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'(i % 3 == 0));
      e = sb.pop_front();
      pulses += int'(bus.done === 1'b1);
      checks++;
      if (bus.q !== e.q || bus.cnt !== e.cnt || bus.done !== e.done) begin
        errors++;
        $display("FAIL post_reset[%0d]: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                 i, bus.q, bus.cnt, bus.done, e.q, e.cnt, e.done);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL post_reset_pulses: got %0d, want 1", pulses);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    step(1'b0, 1'b1, 2'b11, 8'h96, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0);
      void'(sb.pop_front());
    end
    for (int i = 0; i < 8; i++) begin
      if (i < 4) step(1'b0, 1'b0, 2'b11, 8'hFF, 1'b1, 1'b1);
      else       step(1'b0, 1'b1, 2'b00, 8'hFF, 1'b1, 1'b1);
      e = sb.pop_front();
      checks++;
      if (bus.q !== e.q || bus.cnt !== e.cnt || bus.done !== 1'b0 ||
          bus.q !== 8'hE5 || bus.cnt !== 4'd2) begin
        errors++;
        $display("FAIL hold[%0d]: got q=%h cnt=%0d done=%b, want q=e5 cnt=2 done=0",
                 i, bus.q, bus.cnt, bus.done);
      end
    end
  endtask

  task automatic test_mixed();
    exp_t e;
    step(1'b0, 1'b1, 2'b11, 8'hC3, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 9; i++) begin
      if (i < 4)      step(1'b0, 1'b1, 2'b01, 8'h00, 1'(i % 2), 1'b0);
      else if (i < 8) step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'(i % 2));
      else            step(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.q !== e.q || bus.cnt !== e.cnt || bus.done !== e.done ||
          bus.done !== 1'(i == 7)) begin
        errors++;
        $display("FAIL mixed[%0d]: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                 i, bus.q, bus.cnt, bus.done, e.q, e.cnt, e.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   pulses;
    step(1'b0, 1'b1, 2'b11, 8'($urandom), 1'b0, 1'b0);
    void'(sb.pop_front());
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 2'($urandom_range(1, 2)), 8'h00, 1'($urandom), 1'($urandom));
      e = sb.pop_front();
      pulses += int'(bus.done === 1'b1);
      checks++;
      if (bus.q !== e.q || bus.cnt !== e.cnt || bus.done !== e.done ||
          bus.sout_r !== e.q[0] || bus.sout_l !== e.q[W-1]) begin
        errors++;
        $display("FAIL b2b[%0d]: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                 i, bus.q, bus.cnt, bus.done, e.q, e.cnt, e.done);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d, want 2", pulses);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b0;
    bus.en     = 1'b0;
    bus.mode   = 2'b00;
    bus.d      = '0;
    bus.sin_r  = 1'b0;
    bus.sin_l  = 1'b0;
    rbus.en    = 1'b0;
    rbus.mode  = 2'b00;
    rbus.d     = '0;
    rbus.sin_r = 1'b0;
    rbus.sin_l = 1'b0;
    model      = '{q: RV, cnt: 4'd0, done: 1'b0};
    test_reset();
    test_load_shift_right();
    test_shift_left();
    test_rotate();
    test_reset_mid();
    test_hold();
    test_mixed();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits; SHALL be >= 2.
REQ-002 Parameter: RESET_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 Parameter: ROTATE, default 0; 1 = shifts rotate internally, 0 = shifts take serial inputs.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high; one clock, reset is synchronous and active-high.
REQ-006 en  input  1  operation enable; 0 = hold all state.
REQ-007 mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-008 d  input  WIDTH  parallel load data.
REQ-009 sin_r  input  1  serial input entering MSB on shift right.
REQ-010 sin_l  input  1  serial input entering LSB on shift left.
REQ-011 q  output  WIDTH  register contents.
REQ-012 sout_r  output  1  combinational q[0].
REQ-013 sout_l  output  1  combinational q[WIDTH-1].
REQ-014 cnt  output  $clog2(WIDTH+1)  shifts completed since last load/reset/wrap.
REQ-015 done  output  1  registered one-cycle pulse after WIDTH-th shift.

Function
REQ-016 Priority per edge SHALL be: rst > en=0 > mode decode.
REQ-017 en=0: q and cnt SHALL hold, done SHALL be 0 next cycle, mode/d/serial inputs ignored.
REQ-018 en=1, mode=00: q and cnt hold; done <- 0.
REQ-019 en=1, mode=11: q <- d; cnt <- 0; done <- 0; latency one clock.
REQ-020 en=1, mode=01, ROTATE=0: q <- {sin_r, q[WIDTH-1:1]}.
REQ-021 en=1, mode=10, ROTATE=0: q <- {q[WIDTH-2:0], sin_l}.
REQ-022 ROTATE=1: shift right q <- {q[0], q[WIDTH-1:1]}; shift left q <- {q[WIDTH-2:0], q[WIDTH-1]}; sin_r/sin_l ignored.
REQ-023 Each enabled shift (01 or 10) SHALL count: if cnt < WIDTH-1 then cnt <- cnt+1, done <- 0; if cnt == WIDTH-1 then cnt <- 0 (wrap), done <- 1.
REQ-024 Direction changes mid-sequence SHALL NOT reset cnt; left and right shifts count identically.
REQ-025 done SHALL be high for exactly one cycle per wrap; back-to-back wraps after WIDTH further shifts SHALL pulse again.
REQ-026 cnt SHALL never exceed WIDTH-1; no X on any output after first reset edge.
REQ-027 sout_r/sout_l SHALL reflect current q with no added latency.

Reset
REQ-028 On rising clk with rst=1: q <- RESET_VAL, cnt <- 0, done <- 0, regardless of en/mode.
REQ-029 rst asserted without a clk edge SHALL NOT change any output.
REQ-030 Reset mid-sequence SHALL discard partial count; no done pulse SHALL result from the aborted sequence.
REQ-031 First operation SHALL take effect on the first edge with rst=0.

Verification (WIDTH=8 unless stated)
REQ-032 rst=1 one edge, RESET_VAL=8'h3C -> q=8'h3C, cnt=0, done=0, sout_r=0, sout_l=0.
REQ-033 Load d=8'hA5 (en=1, mode=11), then 8 shifts right with sin_r=0 -> sout_r sequence before each shift 1,0,1,0,0,1,0,1; cnt 1..7 then 0; done=1 only the cycle after 8th shift; final q=8'h00.
REQ-034 q=8'h81, one shift left with sin_l=1 -> q=8'h03, cnt=1; ROTATE=1 build: q=8'h01 shift right -> q=8'h80.
REQ-035 After 5 shifts (cnt=5), assert rst one edge -> q=RESET_VAL, cnt=0; 3 further shifts produce no done; 8 shifts from reset produce one done.
REQ-036 en=0 with mode=11, d=8'hFF over 4 edges -> q, cnt unchanged, done=0; en=1 mode=00 likewise holds.
REQ-037 Mix of 4 right and 4 left shifts from load -> done pulses after 8th shift; cnt=0 thereafter.
